// File: rtl/fft_ctrl_pkg.sv
// Shared control definitions for the in-place radix-2 FFT.
//   state_t  : sequencer FSM states
//   SEL_*    : word_sel / ld_sel codes naming the four butterfly operand words.
//              Bit 1 selects the b operand, bit 0 selects the imaginary half of RAM.
package fft_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        WAIT,
        STORE,
        DONE
    } state_t;

    localparam logic [1:0] SEL_A_RE = 2'd0;
    localparam logic [1:0] SEL_A_IM = 2'd1;
    localparam logic [1:0] SEL_B_RE = 2'd2;
    localparam logic [1:0] SEL_B_IM = 2'd3;

endpackage

// File: rtl/fft_bf_index.sv
// Butterfly index generator (purely combinational).
// For stage s and butterfly j it produces the two operand indices and the
// twiddle ROM index of the in-place radix-2 DIT FFT.
//   stage       in  current stage s
//   j           in  butterfly number within the stage
//   a, b        out operand indices, b = a + 2**s
//   twiddle_idx out twiddle ROM index for this butterfly
module fft_bf_index #(
    parameter int N_LOG2  = 9,
    parameter int STAGE_W = $clog2(N_LOG2)
) (
    input  logic [STAGE_W-1:0] stage,
    input  logic [N_LOG2-2:0]  j,
    output logic [N_LOG2-1:0]  a,
    output logic [N_LOG2-1:0]  b,
    output logic [N_LOG2-2:0]  twiddle_idx
);

    logic [N_LOG2-1:0] half;
    logic [N_LOG2-1:0] pos;
    logic [N_LOG2-1:0] grp;

    always_comb begin
        half = N_LOG2'(1) << stage;
        pos  = {1'b0, j} & (half - N_LOG2'(1));
        grp  = {1'b0, j} >> stage;
        // Stage is widened by one bit so s+1 cannot wrap at the last stage.
        a    = (grp << ({1'b0, stage} + (STAGE_W+1)'(1))) | pos;
        b    = a + half;
        // pos < 2**s, so the shifted value always fits in N_LOG2-1 bits.
        twiddle_idx = (N_LOG2-1)'(pos << ((STAGE_W+1)'(N_LOG2 - 1) - {1'b0, stage}));
    end

endmodule

// File: rtl/fft_bf_sequencer.sv
// Top-level sequencer for the in-place radix-2 DIT FFT.
// Walks every stage and butterfly; per butterfly it reads a_re, a_im, b_re,
// b_im, starts the butterfly unit, waits for bf_done, then writes the four
// results back to the same addresses.
//   clk, nrst    clock, asynchronous active-low reset
//   start        begin a full FFT (sampled in IDLE only)
//   bf_done      butterfly result ready (sampled in WAIT only)
//   mem_addr     sample RAM address: real part at k, imaginary part at k+N
//   mem_rd_en    read strobe, RAM data valid the following cycle
//   mem_wr_en    write strobe
//   word_sel     operand word accessed this cycle (SEL_* codes)
//   ld_valid     RAM read data valid this cycle
//   ld_sel       word_sel of the read whose data is on the RAM output
//   twiddle_idx  twiddle ROM index for the current butterfly
//   bf_start     one-cycle pulse, all four operands delivered
//   stage        current stage number
//   busy         high in every state except IDLE
//   done         one-cycle pulse on FFT completion
module fft_bf_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int N_LOG2 = 9,
    parameter int ADDR_W = N_LOG2 + 1
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       start,
    input  logic                       bf_done,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_rd_en,
    output logic                       mem_wr_en,
    output logic [1:0]                 word_sel,
    output logic                       ld_valid,
    output logic [1:0]                 ld_sel,
    output logic [N_LOG2-2:0]          twiddle_idx,
    output logic                       bf_start,
    output logic [$clog2(N_LOG2)-1:0]  stage,
    output logic                       busy,
    output logic                       done
);

    localparam int                  STAGE_W    = $clog2(N_LOG2);
    localparam int                  J_W        = N_LOG2 - 1;
    localparam logic [J_W-1:0]      J_LAST     = '1;
    localparam logic [STAGE_W-1:0]  STAGE_LAST = STAGE_W'(N_LOG2 - 1);

    state_t               state, next_state;
    logic [1:0]           sub, next_sub;        // word counter inside LOAD / STORE
    logic [J_W-1:0]       j, next_j;            // butterfly counter
    logic [STAGE_W-1:0]   stage_cnt, next_stage;
    logic                 wait_first;           // high during the first WAIT cycle
    logic [N_LOG2-1:0]    a, b, base;
    logic                 access;

    fft_bf_index #(
        .N_LOG2  (N_LOG2),
        .STAGE_W (STAGE_W)
    ) u_index (
        .stage       (stage_cnt),
        .j           (j),
        .a           (a),
        .b           (b),
        .twiddle_idx (twiddle_idx)
    );

    // State and counter registers; the load tag pipeline is the same registers delayed.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            sub        <= '0;
            j          <= '0;
            stage_cnt  <= '0;
            wait_first <= 1'b0;
            ld_valid   <= 1'b0;
            ld_sel     <= '0;
        end else begin
            state      <= next_state;
            sub        <= next_sub;
            j          <= next_j;
            stage_cnt  <= next_stage;
            wait_first <= (state == DRAIN);
            ld_valid   <= mem_rd_en;
            ld_sel     <= word_sel;
        end
    end

    // Next-state and counter update.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        next_sub   = sub;
        next_j     = j;
        next_stage = stage_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD;
                    next_sub   = SEL_A_RE;
                end
            end
            LOAD: begin
                next_sub = sub + 2'd1;
                if (sub == SEL_B_IM) next_state = DRAIN;
            end
            DRAIN: next_state = WAIT;
            WAIT: begin
                if (bf_done) next_state = STORE;
            end
            STORE: begin
                next_sub = sub + 2'd1;
                if (sub == SEL_B_IM) begin
                    next_state = LOAD;
                    if (j == J_LAST) begin
                        next_j = '0;
                        if (stage_cnt == STAGE_LAST) begin
                            next_stage = '0;
                            next_state = DONE;
                        end else begin
                            next_stage = stage_cnt + STAGE_W'(1);
                        end
                    end else begin
                        next_j = j + J_W'(1);
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from the registered state and counters.
    always_comb begin
        mem_rd_en = (state == LOAD);
        mem_wr_en = (state == STORE);
        access    = mem_rd_en || mem_wr_en;
        word_sel  = access ? sub : SEL_A_RE;
        base      = word_sel[1] ? b : a;
        mem_addr  = access ? ADDR_W'({word_sel[0], base}) : '0;
        bf_start  = (state == WAIT) && wait_first;
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

    assign stage = stage_cnt;

endmodule
